vga_timing_gen: RTL and testbench

//  Raster timing source driving color_mapper and the ADV7123 DAC. Divides Clk to pixel rate.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_sync_delay.sv | 27 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster types, default VGA 640x480@60 timing and the tile-axis step helper.
// Also imported by color_mapper so both blocks agree on coordinate widths.
package vga_pkg;

   typedef logic [9:0] coord_t;
   typedef logic [3:0] tile_idx_t;
   typedef logic [5:0] tile_off_t;

   typedef struct packed {
      tile_idx_t idx;
      tile_off_t off;
   } tile_pos_t;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_VIS    = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_VIS    = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_SYNC_DLY = 1;
   localparam int DEF_TILE_PX  = 48;
   localparam int DEF_GRID_N   = 10;

   localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // One pixel step along a tile axis: offset rolls into index, index parks at grid_n.
   function automatic tile_pos_t tile_next(tile_pos_t p, int tile_px, int grid_n);
      tile_pos_t r;
      r = p;
      if (p.idx == tile_idx_t'(grid_n)) begin
         r.off = '0;
      end else if (p.off == tile_off_t'(tile_px - 1)) begin
         r.idx = p.idx + tile_idx_t'(1);
         r.off = '0;
      end else begin
         r.off = p.off + tile_off_t'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enabled shift register that lines sync/blank up with the color pipeline.
module vga_sync_delay #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             gclk,
   input  logic             grst_n,
   input  logic             pixel_ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         pipe <= {DEPTH{RST_VAL}};
      end else if (pixel_ce) begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider, DrawX/DrawY, incremental tile index/offset,
// and delayed HS/VS/BLANK_N for the DAC.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_VIS    = DEF_H_VIS,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_VIS    = DEF_V_VIS,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_DLY = DEF_SYNC_DLY,
   parameter int TILE_PX  = DEF_TILE_PX,
   parameter int GRID_N   = DEF_GRID_N
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       pixel_ce,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic [3:0] Tile_Col,
   output logic [3:0] Tile_Row,
   output logic [5:0] Tile_PX,
   output logic [5:0] Tile_PY,
   output logic       grid_on,
   output logic       frame_start,
   output logic       line_start,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       VGA_CLK
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   coord_t        x_cnt, y_cnt;
   tile_pos_t     col, row;
   logic          x_wrap, y_wrap;
   logic          hs_d, vs_d, blank_n_d;
   logic [2:0]    sync_q;

   // Divider: pixel_ce falls on the last Clk of each pixel period.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)      div_cnt <= '0;
      else if (pixel_ce) div_cnt <= '0;
      else               div_cnt <= div_cnt + DW'(1);
   end

   assign pixel_ce = (div_cnt == DW'(CLK_DIV - 1));
   assign VGA_CLK  = (div_cnt >= DW'(CLK_DIV / 2));

   assign x_wrap = (x_cnt == coord_t'(H_TOT - 1));
   assign y_wrap = (y_cnt == coord_t'(V_TOT - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
         col   <= '0;
         row   <= '0;
      end else if (pixel_ce) begin
         x_cnt <= x_wrap ? '0 : x_cnt + coord_t'(1);
         col   <= x_wrap ? '0 : tile_next(col, TILE_PX, GRID_N);
         // Vertical state only moves at end of line.
         if (x_wrap) begin
            y_cnt <= y_wrap ? '0 : y_cnt + coord_t'(1);
            row   <= y_wrap ? '0 : tile_next(row, TILE_PX, GRID_N);
         end
      end
   end

   assign DrawX    = x_cnt;
   assign DrawY    = y_cnt;
   assign Tile_Col = col.idx;
   assign Tile_Row = row.idx;
   assign Tile_PX  = col.off;
   assign Tile_PY  = row.off;
   assign grid_on  = (col.idx < tile_idx_t'(GRID_N)) && (row.idx < tile_idx_t'(GRID_N));

   assign line_start  = pixel_ce && (x_cnt == '0);
   assign frame_start = line_start && (y_cnt == '0);

   assign hs_d      = !((x_cnt >= coord_t'(H_VIS + H_FP)) &&
                        (x_cnt <  coord_t'(H_VIS + H_FP + H_SYNC)));
   assign vs_d      = !((y_cnt >= coord_t'(V_VIS + V_FP)) &&
                        (y_cnt <  coord_t'(V_VIS + V_FP + V_SYNC)));
   assign blank_n_d = (x_cnt < coord_t'(H_VIS)) && (y_cnt < coord_t'(V_VIS));

   // Idle value is syncs deasserted, blanked.
   vga_sync_delay #(
      .DEPTH   (SYNC_DLY),
      .WIDTH   (3),
      .RST_VAL (3'b110)
   ) u_sync_dly (
      .gclk     (Clk),
      .grst_n   (Reset_n),
      .pixel_ce (pixel_ce),
      .d        ({hs_d, vs_d, blank_n_d}),
      .q        (sync_q)
   );

   assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_q;
   assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three raster instances (full VGA, shrunk timing, shrunk with SYNC_DLY=3).
// Expected pixels are keyed by pixel_ce index since the last reset release.
module tb_vga_timing_gen;

   typedef struct {
      int k;
      int x, y, col, row, px, py, grid, hs, vs, bl, fs, ls;
   } exp_t;

   exp_t exp_q [3][$];
   int   n_chk = 0;
   int   n_err = 0;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   logic       pixel_ce [3];
   logic [9:0] draw_x [3];
   logic [9:0] draw_y [3];
   logic [3:0] tile_col [3];
   logic [3:0] tile_row [3];
   logic [5:0] tile_px [3];
   logic [5:0] tile_py [3];
   logic       grid_on [3];
   logic       frame_start [3];
   logic       line_start [3];
   logic       vga_hs [3];
   logic       vga_vs [3];
   logic       vga_blank_n [3];
   logic       vga_sync_n [3];
   logic       vga_clk [3];

   vga_timing_gen #(.SYNC_DLY(1)) u_a (
      .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce[0]), .DrawX(draw_x[0]), .DrawY(draw_y[0]),
      .Tile_Col(tile_col[0]), .Tile_Row(tile_row[0]), .Tile_PX(tile_px[0]), .Tile_PY(tile_py[0]),
      .grid_on(grid_on[0]), .frame_start(frame_start[0]), .line_start(line_start[0]),
      .VGA_HS(vga_hs[0]), .VGA_VS(vga_vs[0]), .VGA_BLANK_N(vga_blank_n[0]),
      .VGA_SYNC_N(vga_sync_n[0]), .VGA_CLK(vga_clk[0]));

   vga_timing_gen #(
      .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_VIS(120), .V_FP(3), .V_SYNC(2), .V_BP(3),
      .TILE_PX(4), .GRID_N(10), .SYNC_DLY(1)
   ) u_b (
      .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce[1]), .DrawX(draw_x[1]), .DrawY(draw_y[1]),
      .Tile_Col(tile_col[1]), .Tile_Row(tile_row[1]), .Tile_PX(tile_px[1]), .Tile_PY(tile_py[1]),
      .grid_on(grid_on[1]), .frame_start(frame_start[1]), .line_start(line_start[1]),
      .VGA_HS(vga_hs[1]), .VGA_VS(vga_vs[1]), .VGA_BLANK_N(vga_blank_n[1]),
      .VGA_SYNC_N(vga_sync_n[1]), .VGA_CLK(vga_clk[1]));

   vga_timing_gen #(
      .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_VIS(120), .V_FP(3), .V_SYNC(2), .V_BP(3),
      .TILE_PX(4), .GRID_N(10), .SYNC_DLY(3)
   ) u_c (
      .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce[2]), .DrawX(draw_x[2]), .DrawY(draw_y[2]),
      .Tile_Col(tile_col[2]), .Tile_Row(tile_row[2]), .Tile_PX(tile_px[2]), .Tile_PY(tile_py[2]),
      .grid_on(grid_on[2]), .frame_start(frame_start[2]), .line_start(line_start[2]),
      .VGA_HS(vga_hs[2]), .VGA_VS(vga_vs[2]), .VGA_BLANK_N(vga_blank_n[2]),
      .VGA_SYNC_N(vga_sync_n[2]), .VGA_CLK(vga_clk[2]));

   task automatic chk(input string nm, input int d, input int k, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d pix%0d: got %0d, want %0d", nm, d, k, act, exp);
      end
   endtask

   task automatic push(input int d, input int k, input int x, input int y, input int col,
                       input int row, input int px, input int py, input int grid, input int hs,
                       input int vs, input int bl, input int fs, input int ls);
      exp_t e;
      e.k = k; e.x = x; e.y = y; e.col = col; e.row = row; e.px = px; e.py = py;
      e.grid = grid; e.hs = hs; e.vs = vs; e.bl = bl; e.fs = fs; e.ls = ls;
      exp_q[d].push_back(e);
   endtask

   task automatic chk_reset(input int d);
      chk("rst_x", d, -1, int'(draw_x[d]), 0);
      chk("rst_y", d, -1, int'(draw_y[d]), 0);
      chk("rst_col", d, -1, int'(tile_col[d]), 0);
      chk("rst_row", d, -1, int'(tile_row[d]), 0);
      chk("rst_px", d, -1, int'(tile_px[d]), 0);
      chk("rst_py", d, -1, int'(tile_py[d]), 0);
      chk("rst_grid", d, -1, int'(grid_on[d]), 1);
      chk("rst_hs", d, -1, int'(vga_hs[d]), 1);
      chk("rst_vs", d, -1, int'(vga_vs[d]), 1);
      chk("rst_blank_n", d, -1, int'(vga_blank_n[d]), 0);
      chk("rst_pixel_ce", d, -1, int'(pixel_ce[d]), 0);
      chk("rst_frame_start", d, -1, int'(frame_start[d]), 0);
      chk("rst_line_start", d, -1, int'(line_start[d]), 0);
      chk("rst_vga_clk", d, -1, int'(vga_clk[d]), 0);
   endtask

   task automatic drain(input int budget);
      int left;
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      for (int i = 0; i < budget && left > 0; i++) begin
         @(posedge Clk);
         left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      end
      chk("drain_pending", 0, -1, left, 0);
   endtask

   //          d  k      x   y   col row px py grid hs vs bl fs ls
   task automatic load_epoch1();
      // Full 800x525 raster, 48-px tiles, one-pixel sync delay.
      push(0,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(0,     1,   1,  0,  0, 0,  1, 0, 1,  1, 1, 1, 0, 0);
      push(0,    47,  47,  0,  0, 0, 47, 0, 1,  1, 1, 1, 0, 0);
      push(0,    48,  48,  0,  1, 0,  0, 0, 1,  1, 1, 1, 0, 0);
      push(0,   479, 479,  0,  9, 0, 47, 0, 1,  1, 1, 1, 0, 0);
      push(0,   480, 480,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(0,   640, 640,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(0,   641, 641,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(0,   656, 656,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(0,   657, 657,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(0,   752, 752,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(0,   753, 753,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(0,   799, 799,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(0,   800,   0,  1,  0, 0,  0, 1, 1,  1, 1, 0, 0, 1);
      push(0,   801,   1,  1,  0, 0,  1, 1, 1,  1, 1, 1, 0, 0);
      // Shrunk raster 80x128: HS low x 68..75, VS low y 123..124, 4-px tiles, grid 40.
      push(1,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(1,     1,   1,  0,  0, 0,  1, 0, 1,  1, 1, 1, 0, 0);
      push(1,     3,   3,  0,  0, 0,  3, 0, 1,  1, 1, 1, 0, 0);
      push(1,     4,   4,  0,  1, 0,  0, 0, 1,  1, 1, 1, 0, 0);
      push(1,    39,  39,  0,  9, 0,  3, 0, 1,  1, 1, 1, 0, 0);
      push(1,    40,  40,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(1,    64,  64,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(1,    65,  65,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(1,    68,  68,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(1,    69,  69,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(1,    76,  76,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(1,    77,  77,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(1,    80,   0,  1,  0, 0,  0, 1, 1,  1, 1, 0, 0, 1);
      push(1,   240,   0,  3,  0, 0,  0, 3, 1,  1, 1, 0, 0, 1);
      push(1,   320,   0,  4,  0, 1,  0, 0, 1,  1, 1, 0, 0, 1);
      push(1,  3120,   0, 39,  0, 9,  0, 3, 1,  1, 1, 0, 0, 1);
      push(1,  3200,   0, 40,  0, 10, 0, 0, 0,  1, 1, 0, 0, 1);
      push(1,  3201,   1, 40,  0, 10, 1, 0, 0,  1, 1, 1, 0, 0);
      push(1,  9600,   0,120,  0, 10, 0, 0, 0,  1, 1, 0, 0, 1);
      push(1,  9601,   1,120,  0, 10, 1, 0, 0,  1, 1, 0, 0, 0);
      push(1,  9840,   0,123,  0, 10, 0, 0, 0,  1, 1, 0, 0, 1);
      push(1,  9841,   1,123,  0, 10, 1, 0, 0,  1, 0, 0, 0, 0);
      push(1, 10000,   0,125,  0, 10, 0, 0, 0,  1, 0, 0, 0, 1);
      push(1, 10001,   1,125,  0, 10, 1, 0, 0,  1, 1, 0, 0, 0);
      push(1, 10239,  79,127, 10, 10, 0, 0, 0,  1, 1, 0, 0, 0);
      push(1, 10240,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(1, 10241,   1,  0,  0, 0,  1, 0, 1,  1, 1, 1, 0, 0);
      // Same shrunk raster with three-pixel sync delay.
      push(2,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(2,     2,   2,  0,  0, 0,  2, 0, 1,  1, 1, 0, 0, 0);
      push(2,     3,   3,  0,  0, 0,  3, 0, 1,  1, 1, 1, 0, 0);
      push(2,    40,  40,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(2,    66,  66,  0, 10, 0,  0, 0, 0,  1, 1, 1, 0, 0);
      push(2,    67,  67,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(2,    70,  70,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(2,    71,  71,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(2,    78,  78,  0, 10, 0,  0, 0, 0,  0, 1, 0, 0, 0);
      push(2,    79,  79,  0, 10, 0,  0, 0, 0,  1, 1, 0, 0, 0);
      push(2,    80,   0,  1,  0, 0,  0, 1, 1,  1, 1, 0, 0, 1);
      push(2,    83,   3,  1,  0, 0,  3, 1, 1,  1, 1, 1, 0, 0);
      push(2,  9842,   2,123,  0, 10, 2, 0, 0,  1, 1, 0, 0, 0);
      push(2,  9843,   3,123,  0, 10, 3, 0, 0,  1, 0, 0, 0, 0);
      push(2, 10240,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(2, 10243,   3,  0,  0, 0,  3, 0, 1,  1, 1, 1, 0, 0);
   endtask

   task automatic load_epoch2();
      push(0,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(0,     1,   1,  0,  0, 0,  1, 0, 1,  1, 1, 1, 0, 0);
      push(0,   800,   0,  1,  0, 0,  0, 1, 1,  1, 1, 0, 0, 1);
      push(1,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(1,     1,   1,  0,  0, 0,  1, 0, 1,  1, 1, 1, 0, 0);
      push(2,     0,   0,  0,  0, 0,  0, 0, 1,  1, 1, 0, 1, 1);
      push(2,     3,   3,  0,  0, 0,  3, 0, 1,  1, 1, 1, 0, 0);
   endtask

   // Monitor: cadence checks for the first 1602 Clk, then scoreboard pops on pixel_ce.
   initial begin
      int   kc [3];
      int   cyc;
      exp_t e;
      kc  = '{0, 0, 0};
      cyc = 0;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            kc  = '{0, 0, 0};
            cyc = 0;
         end else begin
            for (int d = 0; d < 3; d++) begin
               if (cyc < 1602) begin
                  chk("pixel_ce_cadence", d, cyc, int'(pixel_ce[d]), cyc % 2);
                  chk("vga_clk", d, cyc, int'(vga_clk[d]), cyc % 2);
                  chk("sync_n", d, cyc, int'(vga_sync_n[d]), 0);
               end
               if (pixel_ce[d]) begin
                  if (exp_q[d].size() > 0 && exp_q[d][0].k == kc[d]) begin
                     e = exp_q[d].pop_front();
                     chk("draw_x", d, kc[d], int'(draw_x[d]), e.x);
                     chk("draw_y", d, kc[d], int'(draw_y[d]), e.y);
                     chk("tile_col", d, kc[d], int'(tile_col[d]), e.col);
                     chk("tile_row", d, kc[d], int'(tile_row[d]), e.row);
                     chk("tile_px", d, kc[d], int'(tile_px[d]), e.px);
                     chk("tile_py", d, kc[d], int'(tile_py[d]), e.py);
                     chk("grid_on", d, kc[d], int'(grid_on[d]), e.grid);
                     chk("vga_hs", d, kc[d], int'(vga_hs[d]), e.hs);
                     chk("vga_vs", d, kc[d], int'(vga_vs[d]), e.vs);
                     chk("vga_blank_n", d, kc[d], int'(vga_blank_n[d]), e.bl);
                     chk("frame_start", d, kc[d], int'(frame_start[d]), e.fs);
                     chk("line_start", d, kc[d], int'(line_start[d]), e.ls);
                  end
                  kc[d]++;
               end
            end
            cyc++;
         end
      end
   end

   initial begin
      int found;
      load_epoch1();
      repeat (2) @(posedge Clk);
      #1;
      for (int d = 0; d < 3; d++) chk_reset(d);
      #2 Reset_n = 1'b1;
      drain(30000);

      // Mid-line reset, applied between edges at DrawX=300.
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(posedge Clk);
         #3;
         if (draw_x[0] == 10'd300) found = 1;
      end
      chk("reach_x300", 0, -1, found, 1);
      Reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk_reset(d);
      repeat (3) @(posedge Clk);
      load_epoch2();
      #3 Reset_n = 1'b1;
      drain(4000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
